// File: rtl/ibex_instr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_line_buffer
// Description : Single 16-byte instruction line buffer between the core fetch
//               port and instruction memory. Hits answer in one cycle. Misses
//               refill the whole line critical-word-first with wrap-around.
//               Optional hit/miss statistics under IBEX_LINE_BUF_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_instr_line_buffer #(
    parameter int LINE_WORDS = 4  // fixed at 4: tag is addr[31:4], index addr[3:2]
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        setback_i,
    input  logic        inval_i,
    input  logic        core_req_i,
    output logic        core_gnt_o,
    input  logic [31:0] core_addr_i,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_setback;
    logic        w_rst;
    logic [27:0] r_tag;
    logic        r_line_valid;
    logic [31:0] r_data [LINE_WORDS];
    logic [1:0]  r_crit;
    logic [2:0]  r_issued;
    logic [2:0]  r_recv;
    logic        r_fill_bad;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_gnt;
    logic        w_hit;
    logic        w_miss;
    logic        w_mem_req;
    logic        w_rsp;
    logic [1:0]  w_issue_idx;
    logic [1:0]  w_recv_idx;
    logic        w_unused_addr;

    // Setback acts exactly like reset, delayed by one cycle.
    assign w_rst = rst_i | r_setback;

    // Byte offset is always zero for word-aligned fetches.
    assign w_unused_addr = ^core_addr_i[1:0];

    // A request inside the reset cycle is not granted, so it cannot be lost.
    assign w_gnt       = (r_state == S_IDLE) & core_req_i & ~w_rst;
    // A coinciding invalidate forces the request down the miss path.
    assign w_hit       = w_gnt & r_line_valid & ~inval_i & (r_tag == core_addr_i[31:4]);
    assign w_miss      = w_gnt & ~w_hit;
    assign w_mem_req   = (r_state == S_FILL) & ~r_issued[2];
    assign w_issue_idx = r_crit + r_issued[1:0];
    // Responses outside FILL belong to a fill aborted by reset and are dropped.
    assign w_rsp       = (r_state == S_FILL) & mem_rvalid_i & ~r_recv[2];
    assign w_recv_idx  = r_crit + r_recv[1:0];

    assign core_gnt_o    = w_gnt;
    assign core_rvalid_o = r_rvalid;
    assign core_rdata_o  = r_rdata;
    assign core_err_o    = r_err;
    assign mem_req_o     = w_mem_req;
    assign mem_addr_o    = w_mem_req ? {r_tag, w_issue_idx, 2'b00} : 32'd0;

    // Register the delayed setback request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_setback <= 1'b0;
        end else begin
            r_setback <= setback_i;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a miss starts a fill, the 4th response ends it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_state_next = S_FILL;
            S_FILL:  if (w_rsp && (r_recv == 3'd3)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Line control, fill counters and the registered core response.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_tag        <= '0;
            r_crit       <= '0;
            r_line_valid <= 1'b0;
            r_issued     <= '0;
            r_recv       <= '0;
            r_fill_bad   <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inval_i) begin
                        r_line_valid <= 1'b0;
                    end
                    if (w_hit) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= r_data[core_addr_i[3:2]];
                    end else if (w_miss) begin
                        r_tag        <= core_addr_i[31:4];
                        r_crit       <= core_addr_i[3:2];
                        r_line_valid <= 1'b0;
                        r_issued     <= '0;
                        r_recv       <= '0;
                        r_fill_bad   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_mem_req && mem_gnt_i) begin
                        r_issued <= r_issued + 3'd1;
                    end
                    if (w_rsp) begin
                        r_recv <= r_recv + 3'd1;
                        // The first response is the word the core asked for.
                        if (r_recv == 3'd0) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= mem_rdata_i;
                            r_err    <= mem_err_i;
                        end
                    end
                    if ((w_rsp && mem_err_i) || inval_i) begin
                        r_fill_bad <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_line_valid <= ~r_fill_bad & ~inval_i;
                end
                default: begin
                    r_line_valid <= 1'b0;
                end
            endcase
        end
    end

    // Line storage; contents are only used once the line is validated.
    always_ff @(posedge clk_i) begin
        if (w_rsp) begin
            r_data[w_recv_idx] <= mem_rdata_i;
        end
    end

`ifdef IBEX_LINE_BUF_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Count granted hits and misses; both wrap.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_instr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_instr_line_buffer
// Description : Self-checking bench for ibex_instr_line_buffer. A memory model
//               grants and answers fetches; expected core responses are queued
//               at grant time and compared when core_rvalid_o rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_instr_line_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        setback_i = 1'b0;
    logic        inval_i = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_gnt_o;
    logic [31:0] core_addr_i = '0;
    logic        core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    ibex_instr_line_buffer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .setback_i    (setback_i),
        .inval_i      (inval_i),
        .core_req_i   (core_req_i),
        .core_gnt_o   (core_gnt_o),
        .core_addr_i  (core_addr_i),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .core_err_o   (core_err_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {logic [31:0] data; logic err;} exp_t;
    typedef struct packed {logic [31:0] addr; logic err; logic crit; logic stale;} pend_t;

    exp_t        sb[$];
    pend_t       pq[$];
    logic [31:0] gaddr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          fill_gidx = 0;
    int          gnt_limit = 4;
    bit          hold = 1'b0;
    int          err_at = -1;
    int          n_gnt = 0;
    int          n_resp = 0;
    int          fill_rbase = 0;
    int          n_hit = 0;
    int          n_miss = 0;
    bit          flag_hit = 1'b0;
    bit          flag_crit = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // Memory model: answer the oldest granted fetch, then grant the current one.
    always @(negedge clk_i) begin
        pend_t p;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
        mem_gnt_i    = 1'b0;
        if (!hold && pq.size() != 0) begin
            p = pq.pop_front();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(p.addr);
            if (!p.stale) begin
                mem_err_i = p.err;
                if (p.crit) flag_crit = 1'b1;
                n_resp++;
            end
        end
        if (mem_req_o && fill_gidx < gnt_limit) begin
            mem_gnt_i = 1'b1;
            p.addr  = mem_addr_o;
            p.err   = (fill_gidx == err_at);
            p.crit  = (fill_gidx == 0);
            p.stale = 1'b0;
            pq.push_back(p);
            gaddr_q.push_back(mem_addr_o);
            fill_gidx++;
            n_gnt++;
        end
    end

    // Response monitor: rvalid must appear exactly when expected, with queued data.
    always @(posedge clk_i) begin
        exp_t e;
        bit   exp_rv;
        #1;
        exp_rv    = flag_hit | flag_crit;
        flag_hit  = 1'b0;
        flag_crit = 1'b0;
        e         = '0;
        if (exp_rv) begin
            if (sb.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL sb_underflow: response expected but scoreboard empty at %0t", $time);
            end else begin
                e = sb.pop_front();
            end
        end
        if (exp_rv || core_rvalid_o) begin
            n_checks++;
            if (core_rvalid_o !== exp_rv) begin
                n_errors++;
                $display("FAIL rvalid_timing: got %b required %b at %0t", core_rvalid_o, exp_rv, $time);
            end else begin
                n_checks++;
                if ({core_rdata_o, core_err_o} !== {e.data, e.err}) begin
                    n_errors++;
                    $display("FAIL rdata: got %h/err %b required %h/err %b at %0t",
                             core_rdata_o, core_err_o, e.data, e.err, $time);
                end
            end
        end
    end

    task automatic core_req(input logic [31:0] addr, input bit exp_hit);
        bit   got = 1'b0;
        exp_t e;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            core_req_i  = 1'b1;
            core_addr_i = addr;
            #1;
            if (core_gnt_o) got = 1'b1;
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL gnt_timeout: addr %h got no grant, required grant", addr);
            core_req_i = 1'b0;
        end else begin
            e.data = mem_word(addr);
            if (exp_hit) begin
                n_hit++;
                flag_hit = 1'b1;
                e.err    = 1'b0;
            end else begin
                n_miss++;
                fill_gidx  = 0;
                fill_rbase = n_resp;
                e.err      = (err_at == 0);
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_fill();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk_i);
            core_req_i = 1'b0;
            if (n_resp - fill_rbase >= 4) done = 1'b1;
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL fill_timeout: got %0d responses, required 4", n_resp - fill_rbase);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i      = 1'b1;
        core_req_i = 1'b0;
        inval_i    = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        sb.delete();
        flag_hit  = 1'b0;
        flag_crit = 1'b0;
        n_hit     = 0;
        n_miss    = 0;
        for (int i = 0; i < pq.size(); i++) pq[i].stale = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({core_gnt_o, core_rvalid_o, core_err_o, mem_req_o} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got gnt/rv/err/req %b required 0000",
                     {core_gnt_o, core_rvalid_o, core_err_o, mem_req_o});
        end
        n_checks++;
        if ({core_rdata_o, mem_addr_o} !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_data: got rdata %h addr %h required 0", core_rdata_o, mem_addr_o);
        end
        n_checks++;
        if ({hit_cnt_o, miss_cnt_o} !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: got %0d/%0d required 0/0", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_cold_miss();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        gaddr_q.delete();
        core_req(32'h1008, 1'b0);
        wait_fill();
        n_checks++;
        if (gaddr_q.size() != 4) begin
            n_errors++;
            $display("FAIL cold_nreq: got %0d memory requests required 4", gaddr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (gaddr_q[i] !== exp_addr[i]) begin
                    n_errors++;
                    $display("FAIL cold_addr%0d: got %h required %h", i, gaddr_q[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int gb = n_gnt;
        core_req(32'h1000, 1'b1);
        core_req(32'h1004, 1'b1);
        core_req(32'h100C, 1'b1);
        @(negedge clk_i);
        core_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (n_gnt != gb) begin
            n_errors++;
            $display("FAIL hit_memtraffic: got %0d memory grants required 0", n_gnt - gb);
        end
    endtask

    task automatic test_err_third();
        int gb = n_gnt;
        err_at = 2;
        core_req(32'h2000, 1'b0);
        wait_fill();
        err_at = -1;
        core_req(32'h2000, 1'b0);
        wait_fill();
        n_checks++;
        if (n_gnt - gb != 8) begin
            n_errors++;
            $display("FAIL err3_refetch: got %0d memory grants required 8", n_gnt - gb);
        end
        core_req(32'h2008, 1'b1);
        @(negedge clk_i);
        core_req_i = 1'b0;
    endtask

    task automatic test_err_crit();
        int gb;
        int rb;
        err_at = 0;
        gb = n_gnt;
        core_req(32'h5004, 1'b0);
        rb = fill_rbase;
        // Next request is held until the errored fill has fully drained.
        core_req(32'h500C, 1'b0);
        n_checks++;
        if (n_gnt - gb != 4 || n_resp - rb != 4) begin
            n_errors++;
            $display("FAIL errcrit_drain: got %0d grants/%0d responses before next grant required 4/4",
                     n_gnt - gb, n_resp - rb);
        end
        wait_fill();
        err_at = -1;
    endtask

    task automatic test_inval();
        int gb;
        bit seen = 1'b0;
        do_reset();
        gb = n_gnt;
        core_req(32'h3000, 1'b0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            core_req_i = 1'b0;
            if (n_gnt - gb >= 2) seen = 1'b1;
        end
        inval_i = 1'b1;
        @(negedge clk_i);
        inval_i = 1'b0;
        wait_fill();
        core_req(32'h3000, 1'b0);
        wait_fill();
        n_checks++;
        if (n_gnt - gb != 8) begin
            n_errors++;
            $display("FAIL inval_refetch: got %0d memory grants required 8", n_gnt - gb);
        end
        n_checks++;
`ifdef IBEX_LINE_BUF_STATS_EN
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd2) begin
            n_errors++;
            $display("FAIL inval_cnt: got hit %0d miss %0d required 0/2", hit_cnt_o, miss_cnt_o);
        end
`else
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            n_errors++;
            $display("FAIL inval_cnt: got hit %0d miss %0d required 0/0", hit_cnt_o, miss_cnt_o);
        end
`endif
    endtask

    task automatic test_reset_inflight();
        int  gb;
        bit  seen = 1'b0;
        hold      = 1'b1;
        gnt_limit = 2;
        gb = n_gnt;
        core_req(32'h4000, 1'b0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            core_req_i = 1'b0;
            if (n_gnt - gb >= 2) seen = 1'b1;
        end
        test_reset();
        hold      = 1'b0;
        gnt_limit = 4;
        repeat (6) @(negedge clk_i);
        gb = n_gnt;
        core_req(32'h4000, 1'b0);
        wait_fill();
        n_checks++;
        if (n_gnt - gb != 4) begin
            n_errors++;
            $display("FAIL rst_refetch: got %0d memory grants required 4", n_gnt - gb);
        end
    endtask

    task automatic test_setback();
        int gb;
        core_req(32'h4008, 1'b1);
        @(negedge clk_i);
        core_req_i = 1'b0;
        setback_i  = 1'b1;
        @(negedge clk_i);
        setback_i = 1'b0;
        n_hit  = 0;
        n_miss = 0;
        repeat (2) @(negedge clk_i);
        gb = n_gnt;
        core_req(32'h4008, 1'b0);
        wait_fill();
        n_checks++;
        if (n_gnt - gb != 4) begin
            n_errors++;
            $display("FAIL setback_refetch: got %0d memory grants required 4", n_gnt - gb);
        end
        n_checks++;
`ifdef IBEX_LINE_BUF_STATS_EN
        if (hit_cnt_o !== n_hit || miss_cnt_o !== n_miss) begin
            n_errors++;
            $display("FAIL setback_cnt: got %0d/%0d required %0d/%0d", hit_cnt_o, miss_cnt_o, n_hit, n_miss);
        end
`else
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            n_errors++;
            $display("FAIL setback_cnt: got %0d/%0d required 0/0", hit_cnt_o, miss_cnt_o);
        end
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_err_third();
        test_err_crit();
        test_inval();
        test_reset_inflight();
        test_setback();
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: got %0d pending responses required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ibex_instr_line_buffer.md
# ibex_instr_line_buffer

Single-line (16-byte) instruction buffer between the prefetch buffer's instruction bus and instruction memory. It accepts the core-side req/gnt/rvalid protocol. Hits return data in one cycle. Misses refill the whole line from memory with critical-word-first wrap-around ordering, which cuts memory traffic for sequential fetch.

## Interface
Parameters:
- LineWords, 4: words per line; fixed power of two; tag is addr[31:4].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- setback_i  in  1  lockstep setback. Same effect as rst_i, one cycle later.
- inval_i  in  1  FENCE.I invalidate of the line.
- core_req_i  in  1  core request.
- core_gnt_o  out  1  core grant.
- core_addr_i  in  32  word-aligned fetch address.
- core_rvalid_o  out  1  response valid.
- core_rdata_o  out  32  response data.
- core_err_o  out  1  response bus error.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  32  memory word address.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  32  memory response data.
- mem_err_i  in  1  memory response error.
- hit_cnt_o  out  32  hit counter.
- miss_cnt_o  out  32  miss counter.

## Operation
- State: tag_q[31:4], line_valid_q, data_q[4][32].
- FSM states:
  - IDLE
  - FILL: issuing and collecting words.
  - DONE: one cycle, commits line_valid.
- IDLE, core_req_i:
  - core_gnt_o=1 combinationally.
  - Hit = line_valid_q & tag match. Next cycle: core_rvalid_o=1, data_q[addr[3:2]], core_err_o=0.
  - Miss: latch tag, crit=addr[3:2], clear line_valid_q, go to FILL.
- FILL:
  - core_gnt_o=0.
  - mem_req_o=1 while issued<4. mem_addr_o={tag,(crit+issued)[1:0],2'b00}, wrapping mod 4.
  - Each mem_gnt_i increments issued (3-bit). Each mem_rvalid_i writes data_q[(crit+recv)[1:0]] and increments recv (3-bit).
  - Memory may overlap grants and responses. Up to 4 requests may be outstanding.
- Critical word = the word with recv==0. Its response goes to the core the cycle after its mem_rvalid_i, with core_err_o=mem_err_i.
- fill_bad (sticky, cleared on entering FILL) is set by any mem_err_i or inval_i during FILL.
- recv reaches 4 -> DONE. line_valid_q <= ~fill_bad, then IDLE.
- inval_i in IDLE or DONE clears line_valid_q. If inval_i coincides with a hit request in IDLE, the request is treated as a miss.
- An error word is never served from the line, because the line is never validated after an error.
- rst_i or setback_i:
  - IDLE, line_valid_q=0, counters 0, issued=recv=0.
  - Any memory responses still in flight are ignored: mem_rvalid_i in IDLE is dropped.

## Timing
- Reset values: core_gnt_o=0 (core_req_i low), core_rvalid_o=0, core_rdata_o=0, core_err_o=0, mem_req_o=0, mem_addr_o=0, counters 0.
- Hit latency: 1 cycle (gnt in cycle N, rvalid in N+1). Back-to-back hits sustain 1 per cycle. At most one core response is outstanding.
- Miss: gnt in N, mem_req_o from N+1. Core rvalid comes 1 cycle after the critical mem_rvalid_i.
- Earliest next grant: the IDLE cycle after DONE, i.e. 2 cycles after the 4th mem_rvalid_i.
- mem_req_o/mem_addr_o stay stable until mem_gnt_i. mem_req_o deasserts the cycle after the 4th grant.
- Counters are 32-bit and wrap.

## Configuration
- IBEX_LINE_BUF_STATS_EN defined:
  - hit_cnt_o increments on each hit grant.
  - miss_cnt_o increments on each miss grant.
  - Both reset to 0.
- Undefined: both outputs tied to 0 and no counter flops exist. Functional behaviour is otherwise identical.

## Test plan
- Cold miss at 0x0000_1008, memory grants immediately with 1-cycle rvalid:
  - mem_addr_o sequence 0x1008, 0x100C, 0x1000, 0x1004.
  - core_rvalid_o carries the 0x1008 data one cycle after its mem_rvalid.
  - line_valid set after DONE.
- After that fill, requests 0x1000, 0x1004, 0x100C on consecutive cycles: three grants, rvalid each following cycle with the stored words, no mem_req_o.
- Fill of 0x2000 with mem_err_i on the 3rd response:
  - Critical word returned with core_err_o=0.
  - Line not validated; a re-request of 0x2000 misses again.
- Fill with mem_err_i on the critical word: core_err_o=1 with that rvalid; all 4 memory requests still complete before IDLE.
- inval_i asserted mid-fill, then a request to the same line: treated as a miss; with the macro, miss_cnt_o=2, hit_cnt_o=0.
- rst_i asserted with 2 memory requests outstanding:
  - Next cycle: IDLE, all outputs at reset values.
  - Late mem_rvalid_i ignored; the next request misses.
